// File: rtl/gb_bus_ctrl.sv
// Game Boy cartridge-bus sequencer/arbiter in front of a single-port sync RAM.
// Optional statistics counters are built only when GB_BUS_STAT_EN is defined.
module gb_bus_ctrl #(
  parameter int unsigned MIN_LEN = 2,
  parameter int unsigned AW      = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] adr_in,
  input  logic [7:0]    data_in,
  input  logic          nrd,
  input  logic          nwr,
  input  logic          ncs,
  output logic          data_drv,
  output logic [7:0]    data_out,
  output logic [AW-1:0] mem_adr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [7:0]    mem_rdata,
  input  logic          int_req,
  input  logic          int_we,
  input  logic [AW-1:0] int_adr,
  input  logic [7:0]    int_wdata,
  output logic          int_gnt,
  output logic [7:0]    int_rdata,
  output logic          int_rvalid,
  output logic          wr_pulse,
  output logic [15:0]   stat_rd,
  output logic [15:0]   stat_wr,
  output logic [7:0]    stat_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUAL,
    S_RD,
    S_WR,
    S_COMMIT,
    S_ERR
  } state_t;

  localparam logic [3:0] MIN_Q = 4'(MIN_LEN);

  state_t          state_q, state_d;
  logic [3:0]      q_q, q_d;
  logic            kind_wr_q, kind_wr_d;
  logic [AW-1:0]   wadr_q, wadr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            bus_rd_q, bus_rd_d;
  logic            int_rd_q, int_rd_d;
  logic [7:0]      data_out_q, data_out_d;
  logic [7:0]      int_rdata_q, int_rdata_d;

  logic rdc, wrc, errc;

  assign rdc  = !nrd && !ncs &&  nwr;
  assign wrc  = !nwr && !ncs &&  nrd;
  assign errc = !nrd && !nwr && !ncs;

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    kind_wr_d   = kind_wr_q;
    wadr_d      = wadr_q;
    wdata_d     = wdata_q;
    bus_rd_d    = 1'b0;
    int_rd_d    = 1'b0;
    data_drv    = 1'b0;
    mem_adr     = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    int_gnt     = 1'b0;
    wr_pulse    = 1'b0;

    // Capture from the first qualifying sample so even a minimum-length
    // write strobe commits the last address/data seen while it was low.
    if (wrc && (state_q == S_IDLE || state_q == S_QUAL || state_q == S_WR)) begin
      wadr_d  = adr_in;
      wdata_d = data_in;
    end

    case (state_q)
      S_IDLE: begin
        if (errc) begin
          state_d = S_ERR;
        end else if (rdc || wrc) begin
          kind_wr_d = wrc;
          q_d       = 4'd1;
          state_d   = (MIN_Q == 4'd1) ? (wrc ? S_WR : S_RD) : S_QUAL;
          // Prefetch starts on the first low sample so the registered
          // data_out is ready when the drive begins (MIN_LEN >= 2).
          if (rdc) begin
            mem_re   = 1'b1;
            mem_adr  = adr_in;
            bus_rd_d = 1'b1;
          end
        end else if (int_req) begin
          int_gnt = 1'b1;
          mem_adr = int_adr;
          if (int_we) begin
            mem_we    = 1'b1;
            mem_wdata = int_wdata;
          end else begin
            mem_re   = 1'b1;
            int_rd_d = 1'b1;
          end
        end
      end
      S_QUAL: begin
        if (errc) begin
          state_d = S_ERR;
        end else if (kind_wr_q ? wrc : rdc) begin
          q_d = q_q + 4'd1;
          if (q_q + 4'd1 == MIN_Q) state_d = kind_wr_q ? S_WR : S_RD;
          if (!kind_wr_q) begin
            mem_re   = 1'b1;
            mem_adr  = adr_in;
            bus_rd_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        data_drv = 1'b1;
        if (errc) begin
          state_d = S_ERR;
        end else if (rdc) begin
          mem_re   = 1'b1;
          mem_adr  = adr_in;
          bus_rd_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        if (errc)      state_d = S_ERR;
        else if (!wrc) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        mem_we    = 1'b1;
        mem_adr   = wadr_q;
        mem_wdata = wdata_q;
        wr_pulse  = 1'b1;
        state_d   = S_IDLE;
      end
      S_ERR: begin
        if (nrd && nwr && ncs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    data_out_d  = bus_rd_q ? mem_rdata : data_out_q;
    int_rdata_d = int_rd_q ? mem_rdata : int_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      q_q         <= '0;
      kind_wr_q   <= 1'b0;
      wadr_q      <= '0;
      wdata_q     <= '0;
      bus_rd_q    <= 1'b0;
      int_rd_q    <= 1'b0;
      data_out_q  <= '0;
      int_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      kind_wr_q   <= kind_wr_d;
      wadr_q      <= wadr_d;
      wdata_q     <= wdata_d;
      bus_rd_q    <= bus_rd_d;
      int_rd_q    <= int_rd_d;
      data_out_q  <= data_out_d;
      int_rdata_q <= int_rdata_d;
    end
  end

  assign data_out   = data_out_q;
  assign int_rvalid = int_rd_q;
  // Read data is the RAM's own output register, held afterwards.
  assign int_rdata  = int_rd_q ? mem_rdata : int_rdata_q;

`ifdef GB_BUS_STAT_EN
  logic [15:0] stat_rd_q, stat_rd_d;
  logic [15:0] stat_wr_q, stat_wr_d;
  logic [7:0]  stat_err_q, stat_err_d;
  logic        rd_ent, wr_ent, err_ent, glitch;

  always_comb begin
    rd_ent  = (state_d == S_RD)  && (state_q != S_RD);
    wr_ent  = (state_d == S_WR)  && (state_q != S_WR);
    err_ent = (state_d == S_ERR) && (state_q != S_ERR);
    glitch  = (state_q == S_QUAL) && (state_d == S_IDLE);
    stat_rd_d  = stat_rd_q;
    stat_wr_d  = stat_wr_q;
    stat_err_d = stat_err_q;
    if (rd_ent && stat_rd_q != '1) stat_rd_d = stat_rd_q + 16'd1;
    if (wr_ent && stat_wr_q != '1) stat_wr_d = stat_wr_q + 16'd1;
    if ((err_ent || glitch) && stat_err_q != '1) stat_err_d = stat_err_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_q  <= '0;
      stat_wr_q  <= '0;
      stat_err_q <= '0;
    end else begin
      stat_rd_q  <= stat_rd_d;
      stat_wr_q  <= stat_wr_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_rd  = stat_rd_q;
  assign stat_wr  = stat_wr_q;
  assign stat_err = stat_err_q;
`else
  assign stat_rd  = '0;
  assign stat_wr  = '0;
  assign stat_err = '0;
`endif

endmodule

// File: tb/tb_gb_bus_ctrl.sv
// Directed bench for gb_bus_ctrl with a behavioural synchronous RAM.
module tb_gb_bus_ctrl;

`ifdef GB_BUS_STAT_EN
  localparam bit STAT_ON = 1'b1;
`else
  localparam bit STAT_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [6:0] adr_in;
  logic [7:0] data_in;
  logic       nrd, nwr, ncs;
  logic       data_drv;
  logic [7:0] data_out;
  logic [6:0] mem_adr;
  logic [7:0] mem_wdata;
  logic       mem_we, mem_re;
  logic [7:0] mem_rdata;
  logic       int_req, int_we;
  logic [6:0] int_adr;
  logic [7:0] int_wdata;
  logic       int_gnt;
  logic [7:0] int_rdata;
  logic       int_rvalid;
  logic       wr_pulse;
  logic [15:0] stat_rd, stat_wr;
  logic [7:0]  stat_err;

  int n_chk = 0;
  int n_bad = 0;
  int n_we  = 0;
  int n_wp  = 0;

  logic [7:0] ram [0:127];

  gb_bus_ctrl #(.MIN_LEN(2), .AW(7)) dut (
    .clk(clk), .rst(rst), .adr_in(adr_in), .data_in(data_in),
    .nrd(nrd), .nwr(nwr), .ncs(ncs), .data_drv(data_drv), .data_out(data_out),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .int_req(int_req), .int_we(int_we), .int_adr(int_adr),
    .int_wdata(int_wdata), .int_gnt(int_gnt), .int_rdata(int_rdata),
    .int_rvalid(int_rvalid), .wr_pulse(wr_pulse), .stat_rd(stat_rd),
    .stat_wr(stat_wr), .stat_err(stat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_adr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_adr];
    if (mem_we) n_we <= n_we + 1;
    if (wr_pulse) n_wp <= n_wp + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic int_access(input logic we, input logic [6:0] a, input logic [7:0] d,
                            output logic [7:0] rd);
    logic got;
    got = 1'b0;
    rd = '0;
    int_req = 1'b1; int_we = we; int_adr = a; int_wdata = d;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (int_gnt) got = 1'b1;
      tick;
      if (got) break;
    end
    int_req = 1'b0;
    check("int_gnt_seen", 32'(got), 32'd1);
    @(negedge clk);
    check("int_rvalid", 32'(int_rvalid), 32'(!we));
    rd = int_rdata;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    int we0, wp0;
    rst = 1'b1; adr_in = '0; data_in = '0; nrd = 1'b1; nwr = 1'b1; ncs = 1'b1;
    int_req = 1'b0; int_we = 1'b0; int_adr = '0; int_wdata = '0;
    repeat (3) tick;
    rst = 1'b0;
    @(negedge clk);
    check("rst_drv", 32'(data_drv), 0);
    check("rst_dout", 32'(data_out), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_re", 32'(mem_re), 0);
    check("rst_gnt", 32'(int_gnt), 0);
    check("rst_rvalid", 32'(int_rvalid), 0);
    check("rst_wp", 32'(wr_pulse), 0);
    check("rst_stats", {stat_rd[7:0], stat_wr[7:0], stat_err}, 0);
    tick;

    // Preload through the internal port, then read back.
    int_access(1'b1, 7'h12, 8'hA5, rd);
    int_access(1'b1, 7'h20, 8'h5A, rd);
    int_access(1'b0, 7'h12, 8'h00, rd);
    check("int_rdata", 32'(rd), 32'hA5);

    // Bus read: 8 low samples starting at i=0.
    adr_in = 7'h12; nrd = 1'b0; ncs = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) begin nrd = 1'b1; ncs = 1'b1; end
      @(negedge clk);
      check($sformatf("rd_drv%0d", i), 32'(data_drv), 32'(i >= 2 && i <= 8));
      if (i >= 2 && i <= 8) check($sformatf("rd_dout%0d", i), 32'(data_out), 32'hA5);
      tick;
    end
    check("stat_rd", 32'(stat_rd), STAT_ON ? 32'd1 : 32'd0);

    // Bus write: 6 low samples, data changes in the last one.
    we0 = n_we; wp0 = n_wp;
    adr_in = 7'h7F; data_in = 8'h3C; nwr = 1'b0; ncs = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) data_in = 8'h3D;
      if (i == 6) begin nwr = 1'b1; ncs = 1'b1; end
      @(negedge clk);
      check($sformatf("wr_we%0d", i), 32'(mem_we), 32'(i == 7));
      check($sformatf("wr_wp%0d", i), 32'(wr_pulse), 32'(i == 7));
      if (i == 7) begin
        check("wr_adr", 32'(mem_adr), 32'h7F);
        check("wr_data", 32'(mem_wdata), 32'h3D);
      end
      tick;
    end
    check("wr_ram", 32'(ram[7'h7F]), 32'h3D);
    check("wr_we_cnt", 32'(n_we - we0), 1);
    check("wr_wp_cnt", 32'(n_wp - wp0), 1);
    check("stat_wr", 32'(stat_wr), STAT_ON ? 32'd1 : 32'd0);

    // Glitch: single-sample write strobe.
    we0 = n_we;
    nwr = 1'b0; ncs = 1'b0;
    tick;
    nwr = 1'b1; ncs = 1'b1;
    repeat (4) tick;
    check("gl_we_cnt", 32'(n_we - we0), 0);
    check("gl_stat_err", 32'(stat_err), STAT_ON ? 32'd1 : 32'd0);

    // Contention: all strobes low.
    nrd = 1'b0; nwr = 1'b0; ncs = 1'b0; adr_in = 7'h20;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin nrd = 1'b1; nwr = 1'b1; ncs = 1'b1; end
      @(negedge clk);
      check($sformatf("ct_drv%0d", i), 32'(data_drv), 0);
      check($sformatf("ct_acc%0d", i), 32'({mem_we, mem_re}), 0);
      tick;
    end
    check("ct_stat_err", 32'(stat_err), STAT_ON ? 32'd2 : 32'd0);
    nrd = 1'b0; ncs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin nrd = 1'b1; ncs = 1'b1; end
      @(negedge clk);
      check($sformatf("ct_rd_drv%0d", i), 32'(data_drv), 32'(i >= 2 && i <= 4));
      if (i >= 2 && i <= 4) check($sformatf("ct_rd_dout%0d", i), 32'(data_out), 32'h5A);
      tick;
    end

    // Arbitration: internal write requested as the bus read starts.
    adr_in = 7'h12; nrd = 1'b0; ncs = 1'b0;
    int_req = 1'b1; int_we = 1'b1; int_adr = 7'h01; int_wdata = 8'h55;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin nrd = 1'b1; ncs = 1'b1; end
      @(negedge clk);
      check($sformatf("ar_gnt%0d", i), 32'(int_gnt), 32'(i == 5));
      if (i == 5) begin
        check("ar_we", 32'(mem_we), 1);
        check("ar_adr", 32'(mem_adr), 32'h01);
        check("ar_wdata", 32'(mem_wdata), 32'h55);
      end
      tick;
    end
    int_req = 1'b0;
    check("ar_ram", 32'(ram[7'h01]), 32'h55);

    // Reset in the middle of a bus read.
    adr_in = 7'h12; nrd = 1'b0; ncs = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    @(negedge clk);
    check("mr_drv_before", 32'(data_drv), 1);
    tick;
    rst = 1'b0; nrd = 1'b1; ncs = 1'b1;
    int_req = 1'b1; int_we = 1'b0; int_adr = 7'h12;
    @(negedge clk);
    check("mr_drv", 32'(data_drv), 0);
    check("mr_dout", 32'(data_out), 0);
    check("mr_idle_gnt", 32'(int_gnt), 1);
    tick;
    int_req = 1'b0;
    @(negedge clk);
    check("mr_rvalid", 32'(int_rvalid), 1);
    check("mr_rdata", 32'(int_rdata), 32'hA5);
    repeat (2) tick;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
